// File: rtl/upsample_pkg.sv
// upsample_pkg: shared sizes, FSM encoding and tap indexing
// for the upsampled-map window generator.
package upsample_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;
    localparam int ADDR_W_DEF = 6;

    localparam int TAP_ROWS = 3;
    localparam int TAP_COLS = 3;
    localparam int TAP_N    = TAP_ROWS * TAP_COLS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int tap_idx(input int i, input int j);
        return i * TAP_COLS + j;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two map-wide shift lines feeding a 3x3 tap
// register; tap (i,j) sits at taps_o[(i*3+j)*DATA_W +: DATA_W].
module conv_line_buffer
    import upsample_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_i,
    input  logic [DATA_W-1:0]       pix_i,
    output logic [TAP_N*DATA_W-1:0] taps_o
);

    logic [DATA_W-1:0] line0_q [IMG_W];
    logic [DATA_W-1:0] line1_q [IMG_W];
    logic [DATA_W-1:0] tap_q   [TAP_N];

    // Shift one pixel through lines and taps; bottom-right tap is newest
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < IMG_W; k++) begin
                line0_q[k] <= '0;
                line1_q[k] <= '0;
            end
            for (int k = 0; k < TAP_N; k++) begin
                tap_q[k] <= '0;
            end
        end else if (shift_i) begin
            line0_q[0] <= pix_i;
            line1_q[0] <= line0_q[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                line0_q[k] <= line0_q[k-1];
                line1_q[k] <= line1_q[k-1];
            end
            for (int i = 0; i < TAP_ROWS; i++) begin
                for (int j = 0; j < TAP_COLS - 1; j++) begin
                    tap_q[tap_idx(i, j)] <= tap_q[tap_idx(i, j + 1)];
                end
            end
            tap_q[tap_idx(0, TAP_COLS - 1)] <= line1_q[IMG_W-1];
            tap_q[tap_idx(1, TAP_COLS - 1)] <= line0_q[IMG_W-1];
            tap_q[tap_idx(2, TAP_COLS - 1)] <= pix_i;
        end
    end

    // Flatten the tap array onto the output bus
    always_comb begin
        taps_o = '0;
        for (int k = 0; k < TAP_N; k++) begin
            taps_o[k*DATA_W +: DATA_W] = tap_q[k];
        end
    end

endmodule

// File: rtl/upsample_conv_window.sv
// upsample_conv_window: reads the upsampled map once in raster order
// and streams zero-padded 3x3 windows over a valid/ready interface.
module upsample_conv_window
    import upsample_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [TAP_N*DATA_W-1:0]  win_data,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     win_last
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int NPIX  = IMG_W * IMG_H;
    // Pushes needed until the last window is centred in the taps
    localparam int NPUSH = NPIX + IMG_W + 1;
    localparam int CNT_W = $clog2(NPUSH + 1);

    localparam logic [CNT_W-1:0] RD_END    = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] PRIME_END = CNT_W'(IMG_W + 2);
    localparam logic [CNT_W-1:0] PUSH_END  = CNT_W'(NPUSH);
    localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(IMG_W + 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  psh_cnt_q, psh_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              win_v_q, win_v_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic                    can_push;
    logic                    xfer;
    logic                    src_v;
    logic [DATA_W-1:0]       src_pix;
    logic                    push;
    logic [TAP_N*DATA_W-1:0] taps;

    assign can_push  = !win_v_q || win_ready;
    assign xfer      = win_v_q && win_ready;
    assign win_valid = win_v_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_last  = win_v_q && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign rd_addr   = ADDR_W'(rd_cnt_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_PRIME;
            ST_PRIME: if (rd_cnt_q >= PRIME_END) state_d = ST_RUN;
            ST_RUN:   if (rd_cnt_q == RD_END) state_d = ST_DRAIN;
            ST_DRAIN: if (xfer && win_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; reads stop whenever the window slot is blocked
    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        rd_en = ((state_q == ST_PRIME) || (state_q == ST_RUN))
              && (rd_cnt_q != RD_END) && can_push;
    end

    // Counters, skid capture and pixel source selection
    always_comb begin
        rd_cnt_d = rd_cnt_q + CNT_W'(rd_en);
        rvalid_d = rd_en;
        src_v    = 1'b0;
        src_pix  = '0;
        if (skid_v_q) begin
            src_v   = 1'b1;
            src_pix = skid_q;
        end else if (rvalid_q) begin
            src_v   = 1'b1;
            src_pix = rd_data;
        end else if (state_q == ST_DRAIN && psh_cnt_q != PUSH_END) begin
            src_v = 1'b1;
        end
        push      = src_v && can_push;
        psh_cnt_d = psh_cnt_q + CNT_W'(push);

        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (push && skid_v_q) begin
            skid_v_d = 1'b0;
        end
        if (rvalid_q && (skid_v_q || !push)) begin
            skid_v_d = 1'b1;
            skid_d   = rd_data;
        end

        win_v_d = win_v_q;
        if (xfer) begin
            win_v_d = 1'b0;
        end
        if (push && psh_cnt_q >= WIN_FIRST) begin
            win_v_d = 1'b1;
        end

        row_d = row_q;
        col_d = col_q;
        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (state_q == ST_DONE) begin
            rd_cnt_d  = '0;
            psh_cnt_d = '0;
            rvalid_d  = 1'b0;
            skid_v_d  = 1'b0;
            win_v_d   = 1'b0;
            row_d     = '0;
            col_d     = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt_q  <= '0;
            psh_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            skid_v_q  <= 1'b0;
            skid_q    <= '0;
            win_v_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            psh_cnt_q <= psh_cnt_d;
            rvalid_q  <= rvalid_d;
            skid_v_q  <= skid_v_d;
            skid_q    <= skid_d;
            win_v_q   <= win_v_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_lb (
        .clk     (clk),
        .rst     (rst),
        .shift_i (push),
        .pix_i   (src_pix),
        .taps_o  (taps)
    );

    // Zero the taps that fall outside the map
    always_comb begin
        win_data = taps;
        for (int i = 0; i < TAP_ROWS; i++) begin
            for (int j = 0; j < TAP_COLS; j++) begin
                if ((i == 0 && row_q == '0)
                    || (i == TAP_ROWS - 1 && row_q == ROW_LAST)
                    || (j == 0 && col_q == '0)
                    || (j == TAP_COLS - 1 && col_q == COL_LAST)) begin
                    win_data[tap_idx(i, j)*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_upsample_conv_window.sv
// tb_upsample_conv_window: directed frames over an 8x8 ramp map
// with pixel(r,c) = r*8+c+1.
module tb_upsample_conv_window;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;
    localparam int WD = 9 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          win_valid;
    logic          win_ready;
    logic [WD-1:0] win_data;
    logic [2:0]    win_row;
    logic [2:0]    win_col;
    logic          win_last;

    int checks   = 0;
    int failures = 0;

    logic rd_clr = 1'b0;
    int   rd_total = 0;
    int   rd_next  = 0;
    int   rd_bad   = 0;

    logic [WD-1:0] cap [64];

    always #5 clk = ~clk;

    upsample_conv_window dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
    );

    // Buffer model (1-cycle read) plus read-order log
    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(rd_addr) + DW'(1);
        if (rd_clr) begin
            rd_total <= 0;
            rd_next  <= 0;
            rd_bad   <= 0;
        end else if (rd_en) begin
            rd_total <= rd_total + 1;
            if (int'(rd_addr) != rd_next) rd_bad <= rd_bad + 1;
            rd_next <= rd_next + 1;
        end
    end

    function automatic logic [WD-1:0] exp_win(input int r, input int c);
        logic [WD-1:0] v;
        int rr;
        int cc;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            rr = r + k / 3 - 1;
            cc = c + k % 3 - 1;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                v[k*DW +: DW] = DW'(rr * W + cc + 1);
        end
        return v;
    endfunction

    function automatic logic [WD-1:0] pack9(
        input int a0, input int a1, input int a2,
        input int a3, input int a4, input int a5,
        input int a6, input int a7, input int a8);
        logic [WD-1:0] v;
        v = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4),
             DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return v;
    endfunction

    // mode 0: ready=1, 1: random ready, 2: ready=1 + start at t=30
    task automatic run_frame(input int mode, output int nwin,
                             output int t_first, output int t_done);
        bit            fin;
        bit            stall_prev;
        logic [WD-1:0] hd;
        logic [2:0]    hr;
        logic [2:0]    hc;
        logic          hl;
        int            last_hs;
        int            er;
        int            ec;
        nwin = 0;
        t_first = -1;
        t_done = -1;
        fin = 0;
        stall_prev = 0;
        last_hs = -10;
        hd = '0; hr = '0; hc = '0; hl = 1'b0;
        rd_clr = 1'b1;
        @(negedge clk);
        rd_clr = 1'b0;
        win_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            start = (mode == 2 && t == 30);
            if (stall_prev) begin
                checks++;
                if ({win_valid, win_data, win_row, win_col, win_last}
                    !== {1'b1, hd, hr, hc, hl}) begin
                    failures++;
                    $display("FAIL stall_hold t=%0d got v=%b r=%0d c=%0d want r=%0d c=%0d",
                             t, win_valid, win_row, win_col, hr, hc);
                end
            end
            if (done) begin
                checks++;
                if (t != last_hs + 1) begin
                    failures++;
                    $display("FAIL done_timing got t=%0d want t=%0d", t, last_hs + 1);
                end
                t_done = t;
                fin = 1;
            end else begin
                if (win_valid && t_first < 0) t_first = t;
                win_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                stall_prev = win_valid && !win_ready;
                if (stall_prev) begin
                    hd = win_data; hr = win_row; hc = win_col; hl = win_last;
                    checks++;
                    if (rd_en !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_rd_en t=%0d got %b want 0", t, rd_en);
                    end
                end
                if (win_valid && win_ready) begin
                    er = nwin / W;
                    ec = nwin % W;
                    checks++;
                    if ({win_row, win_col, win_last, win_data}
                        !== {3'(er), 3'(ec), (nwin == 63), exp_win(er, ec)}) begin
                        failures++;
                        $display("FAIL window n=%0d got r=%0d c=%0d l=%b d=%h want r=%0d c=%0d l=%b d=%h",
                                 nwin, win_row, win_col, win_last, win_data,
                                 er, ec, (nwin == 63), exp_win(er, ec));
                    end
                    if (nwin < 64) cap[nwin] = win_data;
                    nwin++;
                    last_hs = t;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        win_ready = 1'b1;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL frame_timeout got no done want done within 400 cycles");
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        win_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_en, rd_addr, win_valid, win_data, win_row, win_col, win_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b rd_en=%b v=%b d=%h want all 0",
                     busy, rd_en, win_valid, win_data);
        end
    endtask

    task automatic test_ramp();
        int n, tf, td;
        run_frame(0, n, tf, td);
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL ramp_count got %0d want 64", n);
        end
        checks++;
        if (cap[0] !== pack9(0, 0, 0, 0, 1, 2, 0, 9, 10)) begin
            failures++;
            $display("FAIL ramp_win00 got %h want %h", cap[0], pack9(0, 0, 0, 0, 1, 2, 0, 9, 10));
        end
        checks++;
        if (cap[28] !== pack9(20, 21, 22, 28, 29, 30, 36, 37, 38)) begin
            failures++;
            $display("FAIL ramp_win34 got %h want %h", cap[28], pack9(20, 21, 22, 28, 29, 30, 36, 37, 38));
        end
        checks++;
        if (rd_total != 64 || rd_bad != 0) begin
            failures++;
            $display("FAIL ramp_reads got total=%0d bad=%0d want total=64 bad=0", rd_total, rd_bad);
        end
    endtask

    task automatic test_random_ready();
        int n, tf, td;
        run_frame(1, n, tf, td);
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL rand_count got %0d want 64", n);
        end
        checks++;
        if (rd_total != 64 || rd_bad != 0) begin
            failures++;
            $display("FAIL rand_reads got total=%0d bad=%0d want total=64 bad=0", rd_total, rd_bad);
        end
    endtask

    task automatic test_corner();
        int n, tf, td;
        run_frame(0, n, tf, td);
        checks++;
        if (cap[63] !== pack9(55, 56, 0, 63, 64, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL corner_win77 got %h want %h", cap[63], pack9(55, 56, 0, 63, 64, 0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        int n, tf, td;
        run_frame(2, n, tf, td);
        checks++;
        if (n != 64 || rd_total != 64) begin
            failures++;
            $display("FAIL midstart_frame got wins=%0d reads=%0d want 64/64", n, rd_total);
        end
        run_frame(0, n, tf, td);
        checks++;
        if (n != 64 || rd_total != 64 || rd_bad != 0) begin
            failures++;
            $display("FAIL restart_frame got wins=%0d reads=%0d bad=%0d want 64/64/0", n, rd_total, rd_bad);
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        int t;
        int n, tf, td;
        hs = 0;
        t = 0;
        win_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (hs < 20 && t < 200) begin
            if (win_valid) hs++;
            if (hs < 20) @(negedge clk);
            t++;
        end
        checks++;
        if (hs != 20 || win_row !== 3'd2 || win_col !== 3'd3) begin
            failures++;
            $display("FAIL mid_reach got hs=%0d r=%0d c=%0d want 20 r=2 c=3", hs, win_row, win_col);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_en, rd_addr, win_valid, win_data, win_row, win_col, win_last} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got busy=%b rd_en=%b v=%b r=%0d c=%0d want all 0",
                     busy, rd_en, win_valid, win_row, win_col);
        end
        start = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_during_reset got busy=%b want 0", busy);
        end
        run_frame(0, n, tf, td);
        checks++;
        if (n != 64 || rd_total != 64 || rd_bad != 0) begin
            failures++;
            $display("FAIL post_reset_frame got wins=%0d reads=%0d bad=%0d want 64/64/0", n, rd_total, rd_bad);
        end
    endtask

    task automatic test_throughput();
        int n, tf, td;
        run_frame(0, n, tf, td);
        checks++;
        if (tf < 0 || tf > 11) begin
            failures++;
            $display("FAIL first_valid_latency got %0d want <= 11", tf);
        end
        checks++;
        if (td < 0 || td > 76) begin
            failures++;
            $display("FAIL done_latency got %0d want <= 76", td);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        win_ready = 1'b0;
        test_reset();
        test_ramp();
        test_random_ready();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        test_throughput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
